// File: rtl/servo_pkg.sv
// servo_pkg: debounce state encoding, default rates and divisor sizing helper
package servo_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_PRESS, PRESSED, HELD, WAIT_RELEASE} db_state_t;
    localparam int DEF_CLK_HZ  = 50_000_000;
    localparam int DEF_FAST_HZ = 10_000;
    localparam int DEF_SLOW_HZ = 10;
    function automatic int div_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction
endpackage

// File: rtl/debounce_fsm.sv
// debounce_fsm: 2-flop synchronizer plus stable-time debouncer giving one press strobe
module debounce_fsm
    import servo_pkg::*;
#(
    parameter int N = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic press
);
    localparam int CW = div_w(N);
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    logic          sync1_q, sync2_q;
    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // the count is only meaningful in the two WAIT states; elsewhere it free-runs harmlessly
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            IDLE: if (sync2_q) begin
                state_d = WAIT_PRESS;
                cnt_d   = '0;
            end
            WAIT_PRESS: state_d = !sync2_q ? IDLE : (cnt_q == CNT_MAX) ? PRESSED : WAIT_PRESS;
            PRESSED: state_d = HELD;
            HELD: if (!sync2_q) begin
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
            end
            WAIT_RELEASE: state_d = sync2_q ? HELD : (cnt_q == CNT_MAX) ? IDLE : WAIT_RELEASE;
            default: state_d = IDLE;
        endcase
    end

    assign press = (state_q == PRESSED);
endmodule

// File: rtl/servo_input_cond.sv
// servo_input_cond: phase-aligned tick dividers and debounced speed/enable controls
module servo_input_cond
    import servo_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int FAST_HZ     = DEF_FAST_HZ,
    parameter int SLOW_HZ     = DEF_SLOW_HZ,
    parameter int DEBOUNCE_MS = 20,
    parameter int SPEED_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_vel_raw,
    input  logic               btn_en_raw,
    output logic               tick_fast,
    output logic               tick_slow,
    output logic               vel_pulse,
    output logic [SPEED_W-1:0] speed,
    output logic               enable
);
    localparam int DIV_FAST = CLK_HZ / FAST_HZ;
    localparam int DIV_SLOW = FAST_HZ / SLOW_HZ;
    localparam int DB_N     = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int FW       = div_w(DIV_FAST);
    localparam int SW       = div_w(DIV_SLOW);
    localparam logic [FW-1:0] FAST_MAX = FW'(DIV_FAST - 1);
    localparam logic [SW-1:0] SLOW_MAX = SW'(DIV_SLOW - 1);

    logic [FW-1:0]      fast_cnt_q, fast_cnt_d;
    logic [SW-1:0]      slow_cnt_q, slow_cnt_d;
    logic               tick_fast_q, tick_fast_d, tick_slow_q, tick_slow_d;
    logic               vel_pulse_q, vel_pulse_d, enable_q, enable_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               vel_press, en_press, fast_wrap, slow_wrap;

    debounce_fsm #(.N(DB_N)) u_vel (.clk(clk), .rst(rst), .raw_in(btn_vel_raw), .press(vel_press));
    debounce_fsm #(.N(DB_N)) u_en  (.clk(clk), .rst(rst), .raw_in(btn_en_raw),  .press(en_press));

    // slow counter steps on the same wrap that raises tick_fast, so tick_slow always lands on one
    always_comb begin
        fast_wrap   = (fast_cnt_q == FAST_MAX);
        slow_wrap   = fast_wrap && (slow_cnt_q == SLOW_MAX);
        fast_cnt_d  = fast_wrap ? '0 : fast_cnt_q + FW'(1);
        slow_cnt_d  = slow_wrap ? '0 : fast_wrap ? slow_cnt_q + SW'(1) : slow_cnt_q;
        tick_fast_d = fast_wrap;
        tick_slow_d = slow_wrap;
        vel_pulse_d = vel_press;
        speed_d     = speed_q + SPEED_W'(vel_press);
        enable_d    = enable_q ^ en_press;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fast_cnt_q  <= '0;
            slow_cnt_q  <= '0;
            tick_fast_q <= 1'b0;
            tick_slow_q <= 1'b0;
            vel_pulse_q <= 1'b0;
            speed_q     <= '0;
            enable_q    <= 1'b0;
        end else begin
            fast_cnt_q  <= fast_cnt_d;
            slow_cnt_q  <= slow_cnt_d;
            tick_fast_q <= tick_fast_d;
            tick_slow_q <= tick_slow_d;
            vel_pulse_q <= vel_pulse_d;
            speed_q     <= speed_d;
            enable_q    <= enable_d;
        end
    end

    assign tick_fast = tick_fast_q;
    assign tick_slow = tick_slow_q;
    assign vel_pulse = vel_pulse_q;
    assign speed     = speed_q;
    assign enable    = enable_q;
endmodule
